// File: rtl/beatmap_pkg.sv
// beatmap_pkg: shared code constants and types for the beatmap note reader
package beatmap_pkg;
  localparam int BASE_CODE = 100;
  localparam int STEP_CODE = 4;
  localparam int LAST_CODE = 116;
  typedef logic [7:0] note_code_t;
  typedef enum logic {SYNC, RUN} reader_state_t;
endpackage

// File: rtl/beatmap_fifo.sv
// beatmap_fifo: DEPTH x 8 sync FIFO; a pop frees the slot for a same-cycle push when full
module beatmap_fifo
  import beatmap_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  note_code_t din,
  output note_code_t dout,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count
);
  note_code_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/beatmap_note_reader.sv
// beatmap_note_reader: aligns and checks the beatmap code stream, queues notes, releases one per beat_tick
module beatmap_note_reader
  import beatmap_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int BASE = BASE_CODE,
  parameter int STEP = STEP_CODE,
  parameter int LAST = LAST_CODE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_en,
  input  logic [7:0] data,
  input  logic       beat_tick,
  input  logic       clr_flags,
  output logic       note_valid,
  output logic [2:0] note_lane,
  output logic [7:0] note_code,
  output logic [3:0] fill,
  output logic       overflow,
  output logic       underrun,
  output logic       seq_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int SH = $clog2(STEP);
  localparam note_code_t B = note_code_t'(BASE);
  localparam note_code_t S = note_code_t'(STEP);
  localparam note_code_t L = note_code_t'(LAST);
  reader_state_t state, state_n;
  note_code_t expected, expected_n, head, diff;
  logic hit, resync, wr, seq_set, ovf_set, und_set, pop_ok, full, empty;
  logic [AW:0] count;
  // A BASE code always restarts the sequence, even when it breaks the one in progress
  always_comb begin
    hit = state == RUN && data == expected;
    resync = data == B && !hit;
    wr = data_en && (hit || resync);
    seq_set = data_en && state == RUN && !hit;
    expected_n = !data_en ? expected : resync ? B + S : hit ? (data == L ? B : expected + S) : expected;
    state_n = !data_en ? state : wr ? RUN : SYNC;
  end
  assign pop_ok = beat_tick && !empty;
  assign ovf_set = wr && full && !beat_tick;
  assign und_set = beat_tick && empty;
  assign diff = head - B;
  assign fill = 4'(count);
  beatmap_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(wr), .pop(beat_tick), .din(data),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= SYNC;
      expected <= B;
    end else begin
      state <= state_n;
      expected <= expected_n;
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      note_valid <= 1'b0;
      note_code <= '0;
      note_lane <= '0;
      overflow <= 1'b0;
      underrun <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      note_valid <= pop_ok;
      if (pop_ok) begin
        note_code <= head;
        note_lane <= 3'(diff >> SH);
      end
      overflow <= ovf_set || (overflow && !clr_flags);
      underrun <= und_set || (underrun && !clr_flags);
      seq_err <= seq_set || (seq_err && !clr_flags);
    end
endmodule
